// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared segment patterns, scan FSM states and select decode
// Contents: SEG_0..SEG_F and SEG_BLANK (active-low, g..a order), SEG_TABLE
// (entry i is the pattern for hex digit i), scan_state_t, sel_decode().
package ssd_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Packed so that SEG_TABLE[i] is the pattern for digit i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} scan_state_t;

  // Returns {valid, index}; valid only when exactly one select is low.
  function automatic logic [2:0] sel_decode(input logic [3:0] an_n);
    case (an_n)
      4'b1110: return {1'b1, 2'd0};
      4'b1101: return {1'b1, 2'd1};
      4'b1011: return {1'b1, 2'd2};
      4'b0111: return {1'b1, 2'd3};
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ssd_scan_reader_if.sv
// rtl/ssd_scan_reader_if.sv - display bus and frame stream of the scan reader
// Signals: seg_n[6:0], an_n[3:0] (display bus, active-low); frame_data[15:0],
// frame_blank[3:0], frame_err[3:0], frame_valid, frame_ready, overrun.
// master: the reader (consumes display bus, produces frames); slave: its peer.
interface ssd_scan_reader_if;

  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] frame_data;
  logic [3:0]  frame_blank;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;

  modport master (
    input  seg_n, an_n, frame_ready,
    output frame_data, frame_blank, frame_err, frame_valid, overrun
  );

  modport slave (
    output seg_n, an_n, frame_ready,
    input  frame_data, frame_blank, frame_err, frame_valid, overrun
  );

endinterface

// File: rtl/ssd_seg_decode.sv
// rtl/ssd_seg_decode.sv - combinational seven-segment pattern to nibble lookup
// Ports: seg_n[6:0] in (active-low pattern); nibble[3:0] out (0 when blank or
// unknown); blank out (all segments off); err out (not hex and not blank).
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  logic hit;

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_n == SEG_TABLE[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
    blank = (seg_n == SEG_BLANK);
    err   = !hit && !blank;
  end

endmodule

// File: rtl/ssd_scan_reader.sv
// rtl/ssd_scan_reader.sv - recovers 4-digit frames from a multiplexed display bus
// Ports: clk, rst_n (async active-low); bus (ssd_scan_reader_if.master):
// seg_n/an_n in, frame_data/frame_blank/frame_err/frame_valid/overrun out,
// frame_ready in.
module ssd_scan_reader
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES = 8,
  parameter int NUM_DIGITS    = 4
) (
  input logic clk,
  input logic rst_n,
  ssd_scan_reader_if.master bus
);

  localparam logic [7:0]            STABLE_CNT = 8'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ALL_DIGITS = '1;

  logic [3:0]            samp_an, prev_an;
  logic [6:0]            samp_seg, prev_seg;
  scan_state_t           state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic                  capture;
  logic [2:0]            sel;
  logic                  sel_ok;
  logic [1:0]            sel_idx;
  logic                  same;
  logic [3:0]            dec_nibble;
  logic                  dec_blank, dec_err;
  logic [NUM_DIGITS-1:0] mask, mask_nxt;
  logic                  frame_done;
  logic [15:0]           stg_data, frame_data_q;
  logic [3:0]            stg_blank, stg_err, frame_blank_q, frame_err_q;
  logic                  frame_valid_q, overrun_q;

  assign sel        = sel_decode(samp_an);
  assign sel_ok     = sel[2];
  assign sel_idx    = sel[1:0];
  assign same       = ({samp_an, samp_seg} == {prev_an, prev_seg});
  // Mask is only full for the single cycle after the last digit lands.
  assign frame_done = (mask == ALL_DIGITS);

  ssd_seg_decode u_dec (
    .seg_n  (samp_seg),
    .nibble (dec_nibble),
    .blank  (dec_blank),
    .err    (dec_err)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_ok) begin
          state_nxt = SETTLE;
          cnt_nxt   = 8'd1;
        end
      end
      SETTLE: begin
        if (!sel_ok) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else if (!same) begin
          cnt_nxt = 8'd1;
        end else if (cnt >= STABLE_CNT) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else if (cnt != 8'hFF) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      HOLD: begin
        // Leave only on a change so each select period captures once.
        if (!same) begin
          if (sel_ok) begin
            state_nxt = SETTLE;
            cnt_nxt   = 8'd1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_comb begin
    mask_nxt = frame_done ? '0 : mask;
    if (capture) mask_nxt[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_an       <= '0;
      samp_seg      <= '0;
      prev_an       <= '0;
      prev_seg      <= '0;
      state         <= IDLE;
      cnt           <= '0;
      mask          <= '0;
      stg_data      <= '0;
      stg_blank     <= '0;
      stg_err       <= '0;
      frame_data_q  <= '0;
      frame_blank_q <= '0;
      frame_err_q   <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      samp_an  <= bus.an_n;
      samp_seg <= bus.seg_n;
      prev_an  <= samp_an;
      prev_seg <= samp_seg;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mask     <= mask_nxt;
      if (capture) begin
        stg_data[{sel_idx, 2'b00} +: 4] <= dec_nibble;
        stg_blank[sel_idx]              <= dec_blank;
        stg_err[sel_idx]                <= dec_err;
      end
      if (frame_done) begin
        frame_data_q  <= stg_data;
        frame_blank_q <= stg_blank;
        frame_err_q   <= stg_err;
        frame_valid_q <= 1'b1;
        overrun_q     <= frame_valid_q && !bus.frame_ready;
      end else begin
        overrun_q <= 1'b0;
        if (frame_valid_q && bus.frame_ready) frame_valid_q <= 1'b0;
      end
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.frame_blank = frame_blank_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_ssd_scan_reader.sv
// tb/tb_ssd_scan_reader.sv - self-checking bench for ssd_scan_reader
module tb_ssd_scan_reader;

  localparam int STABLE = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  ssd_scan_reader_if bus ();

  ssd_scan_reader #(
    .STABLE_CYCLES (STABLE),
    .NUM_DIGITS    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [10:0] last_inp;
  bit          have_last;
  int          run_len;
  bit          cap_due;
  logic [3:0]  cap_an;
  logic [6:0]  cap_seg;
  logic [15:0] st_data;
  logic [3:0]  st_blank, st_err, mask;
  bit          full_due;
  logic [15:0] m_data;
  logic [3:0]  m_blank, m_err;
  bit          m_valid, m_ovr;

  // monitor
  int          vcycles, ovr_cnt;
  logic [15:0] last_data;
  logic [3:0]  last_blank, last_err;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard active-high gfedcba digit shapes, inverted for the active-low bus.
  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] hi;
    case (d)
      0: hi = 7'h3F;  1: hi = 7'h06;  2: hi = 7'h5B;  3: hi = 7'h4F;
      4: hi = 7'h66;  5: hi = 7'h6D;  6: hi = 7'h7D;  7: hi = 7'h07;
      8: hi = 7'h7F;  9: hi = 7'h6F;  10: hi = 7'h77; 11: hi = 7'h7C;
      12: hi = 7'h39; 13: hi = 7'h5E; 14: hi = 7'h79; default: hi = 7'h71;
    endcase
    return 7'h7F ^ hi;
  endfunction

  function automatic int idx_of(input logic [3:0] an);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] m;
      m = 4'b1111;
      m[i] = 1'b0;
      if (an == m) return i;
    end
    return -1;
  endfunction

  task automatic ref_decode(input logic [6:0] seg, output logic [3:0] nib,
                            output logic bl, output logic er);
    nib = 4'h0;
    bl  = (seg == 7'h7F);
    er  = !bl;
    for (int d = 0; d < 16; d++) begin
      if (seg == seg_of(d)) begin
        nib = 4'(d);
        er  = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    last_inp = '0; have_last = 0; run_len = 0; cap_due = 0;
    cap_an = '0; cap_seg = '0;
    st_data = '0; st_blank = '0; st_err = '0; mask = '0; full_due = 0;
    m_data = '0; m_blank = '0; m_err = '0; m_valid = 0; m_ovr = 0;
  endtask

  // One clock edge: a digit is taken once a run of STABLE+1 identical valid
  // samples has been seen; the frame appears one edge after the 4th digit.
  task automatic model_step();
    logic [10:0] inp;
    logic [3:0]  nib;
    logic        bl, er;
    int          ix;
    if (full_due) begin
      m_ovr   = m_valid && !bus.frame_ready;
      m_data  = st_data;
      m_blank = st_blank;
      m_err   = st_err;
      m_valid = 1;
      mask    = '0;
    end else begin
      m_ovr = 0;
      if (m_valid && bus.frame_ready) m_valid = 0;
    end
    if (cap_due) begin
      ix = idx_of(cap_an);
      ref_decode(cap_seg, nib, bl, er);
      st_data[ix*4 +: 4] = nib;
      st_blank[ix] = bl;
      st_err[ix]   = er;
      mask[ix]     = 1'b1;
    end
    full_due = (mask == 4'hF);
    inp = {bus.an_n, bus.seg_n};
    if (have_last && inp == last_inp) run_len++;
    else run_len = 1;
    last_inp  = inp;
    have_last = 1;
    cap_due = (idx_of(bus.an_n) >= 0) && (run_len == STABLE + 1);
    cap_an  = bus.an_n;
    cap_seg = bus.seg_n;
  endtask

  always begin
    @(posedge clk);
    if (rst_n) begin
      model_step();
      #1;
      check("cyc_valid", 16'(bus.frame_valid), 16'(m_valid));
      check("cyc_overrun", 16'(bus.overrun), 16'(m_ovr));
      check("cyc_data", bus.frame_data, m_data);
      check("cyc_blank", 16'(bus.frame_blank), 16'(m_blank));
      check("cyc_err", 16'(bus.frame_err), 16'(m_err));
      if (bus.frame_valid) begin
        vcycles++;
        last_data  = bus.frame_data;
        last_blank = bus.frame_blank;
        last_err   = bus.frame_err;
      end
      if (bus.overrun) ovr_cnt++;
    end
  end

  task automatic clear_mon();
    vcycles = 0; ovr_cnt = 0; last_data = '0; last_blank = '0; last_err = '0;
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    bus.an_n  = an;
    bus.seg_n = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan4(input int d0, input int d1, input int d2, input int d3);
    show(4'hE, seg_of(d0), 10);
    show(4'hD, seg_of(d1), 10);
    show(4'hB, seg_of(d2), 10);
    show(4'h7, seg_of(d3), 10);
  endtask

  initial begin
    model_reset();
    clear_mon();
    bus.an_n        = 4'hF;
    bus.seg_n       = 7'h7F;
    bus.frame_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid", 16'(bus.frame_valid), 16'h0);
    check("reset_data", bus.frame_data, 16'h0);
    check("reset_overrun", 16'(bus.overrun), 16'h0);
    rst_n = 1'b1;
    show(4'hF, 7'h7F, 4);

    // basic scan
    clear_mon();
    scan4(1, 2, 3, 4);
    show(4'hF, 7'h7F, 12);
    check("basic_vcycles", 16'(vcycles), 16'd1);
    check("basic_data", last_data, 16'h4321);
    check("basic_blank", 16'(last_blank), 16'h0);
    check("basic_err", 16'(last_err), 16'h0);

    // short glitch on digit 0 must not be captured
    clear_mon();
    show(4'hE, seg_of(8), 5);
    show(4'hE, seg_of(10), 10);
    show(4'hD, seg_of(5), 10);
    show(4'hB, seg_of(6), 10);
    show(4'h7, seg_of(7), 10);
    show(4'hF, 7'h7F, 12);
    check("glitch_vcycles", 16'(vcycles), 16'd1);
    check("glitch_data", last_data, 16'h765A);

    // blank and unknown patterns
    clear_mon();
    show(4'hE, seg_of(0), 10);
    show(4'hD, seg_of(9), 10);
    show(4'hB, 7'h7F, 10);
    show(4'h7, 7'h7E, 10);
    show(4'hF, 7'h7F, 12);
    check("blankerr_data", last_data, 16'h0090);
    check("blankerr_blank", 16'(last_blank), 16'h4);
    check("blankerr_err", 16'(last_err), 16'h8);

    // two frames while not ready
    clear_mon();
    bus.frame_ready = 1'b0;
    scan4(1, 1, 1, 1);
    show(4'hF, 7'h7F, 4);
    scan4(2, 2, 2, 2);
    show(4'hF, 7'h7F, 4);
    check("ovr_count", 16'(ovr_cnt), 16'd1);
    check("ovr_valid", 16'(bus.frame_valid), 16'h1);
    check("ovr_data", bus.frame_data, 16'h2222);
    bus.frame_ready = 1'b1;
    @(negedge clk);
    check("accept_valid", 16'(bus.frame_valid), 16'h0);

    // illegal selects in the middle of a scan
    clear_mon();
    show(4'hF, 7'h7F, 4);
    show(4'hE, seg_of(1), 10);
    show(4'hD, seg_of(2), 10);
    show(4'hC, seg_of(3), 12);
    show(4'hB, seg_of(3), 4);
    show(4'hF, seg_of(3), 12);
    check("nosel_vcycles_mid", 16'(vcycles), 16'd0);
    show(4'hB, seg_of(3), 10);
    show(4'h7, seg_of(4), 10);
    show(4'hF, 7'h7F, 12);
    check("nosel_vcycles", 16'(vcycles), 16'd1);
    check("nosel_data", last_data, 16'h4321);

    // async reset after three digits, with a frame pending
    bus.frame_ready = 1'b0;
    scan4(5, 5, 5, 5);
    show(4'hE, seg_of(1), 10);
    show(4'hD, seg_of(2), 10);
    show(4'hB, seg_of(3), 10);
    check("prereset_data", bus.frame_data, 16'h5555);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("areset_valid", 16'(bus.frame_valid), 16'h0);
    check("areset_data", bus.frame_data, 16'h0);
    check("areset_blank", 16'(bus.frame_blank), 16'h0);
    check("areset_err", 16'(bus.frame_err), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.frame_ready = 1'b1;
    clear_mon();
    show(4'h7, seg_of(12), 10);
    show(4'hB, seg_of(13), 10);
    show(4'hD, seg_of(14), 10);
    show(4'hE, seg_of(15), 10);
    show(4'hF, 7'h7F, 12);
    check("postreset_vcycles", 16'(vcycles), 16'd1);
    check("postreset_data", last_data, 16'hCDEF);

    // randomized scanning against the model
    for (int k = 0; k < 400; k++) begin
      logic [3:0] an;
      logic [6:0] seg;
      int         r;
      r = int'($urandom_range(0, 99));
      if (r < 85) an = 4'hF ^ (4'b1 << $urandom_range(0, 3));
      else an = 4'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 65) seg = seg_of(int'($urandom_range(0, 15)));
      else if (r < 80) seg = 7'h7F;
      else seg = 7'($urandom);
      bus.frame_ready = ($urandom_range(0, 3) != 0);
      show(an, seg, int'($urandom_range(1, 14)));
    end
    bus.frame_ready = 1'b1;
    show(4'hF, 7'h7F, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
